// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath blocks: sizing defaults, the
// register-file clear FSM encoding and a constant log2 helper.
package mips_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 32;

    typedef enum logic {
        StIdle     = 1'b0,
        StClearing = 1'b1
    } rf_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux, optional same-cycle write
// forwarding (port 1 wins) and the hardwired zero register.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b1,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic [AW-1:0]         ra_i,
    input  logic [DATA_WIDTH-1:0] mem_i [DEPTH],
    input  logic                  we0_i,
    input  logic [AW-1:0]         wa0_i,
    input  logic [DATA_WIDTH-1:0] wd0_i,
    input  logic                  we1_i,
    input  logic [AW-1:0]         wa1_i,
    input  logic [DATA_WIDTH-1:0] wd1_i,
    output logic [DATA_WIDTH-1:0] rd_o
);

    always_comb begin
        rd_o = mem_i[ra_i];
        if (BYPASS) begin
            if (we1_i && (wa1_i == ra_i)) begin
                rd_o = wd1_i;
            end else if (we0_i && (wa0_i == ra_i)) begin
                rd_o = wd0_i;
            end
        end
        if (ZERO_REG && (ra_i == '0)) begin
            rd_o = '0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD read ports, two write ports, async reset of
// all entries and a sequential bulk-clear engine that sweeps one entry per cycle.
module reg_file_mp
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned NUM_RD     = 2,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b1,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_RD*AW-1:0]         RA,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD,
    input  logic                         WE0,
    input  logic [AW-1:0]                WA0,
    input  logic [DATA_WIDTH-1:0]        WD0,
    input  logic                         WE1,
    input  logic [AW-1:0]                WA1,
    input  logic [DATA_WIDTH-1:0]        WD1,
    input  logic                         CLR_REQ,
    output logic                         BUSY,
    output logic                         CLR_DONE
);

    rf_state_e             state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  idle;
    logic                  we0_eff, we1_eff;

    assign idle    = (state_q == StIdle);
    // Writes are dropped (not queued) while clearing and never land on entry 0.
    assign we0_eff = idle && WE0 && !(ZERO_REG && (WA0 == '0));
    assign we1_eff = idle && WE1 && !(ZERO_REG && (WA1 == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (CLR_REQ) begin
                    state_d = StClearing;
                    idx_d   = '0;
                end
            end
            StClearing: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == StClearing) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (we0_eff) mem_q[WA0] <= WD0;
            if (we1_eff) mem_q[WA1] <= WD1;
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        rf_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .BYPASS    (BYPASS),
            .ZERO_REG  (ZERO_REG)
        ) u_rd_port (
            .ra_i (RA[p*AW +: AW]),
            .mem_i(mem_q),
            .we0_i(we0_eff),
            .wa0_i(WA0),
            .wd0_i(WD0),
            .we1_i(we1_eff),
            .wa1_i(WA1),
            .wd1_i(WD1),
            .rd_o (RD[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign BUSY     = (state_q == StClearing);
    assign CLR_DONE = done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations driven in lockstep and compared
// every cycle against an array-based model, plus directed literal checks.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [4*AW-1:0] ra;
    logic [4*DW-1:0] rd_a;
    logic [2*DW-1:0] rd_b;
    logic            we0, we1, clr_req;
    logic [AW-1:0]   wa0, wa1;
    logic [DW-1:0]   wd0, wd1;
    logic            busy_a, done_a, busy_b, done_b;

    int errors = 0;
    int checks = 0;

    // Model state: stored contents per configuration and clear cycles remaining.
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    int            clr_left;
    logic          done_m;

    always #5 CLK = ~CLK;

    // A: four ports, forwarding, zero register.  B: two ports, no forwarding, no zero register.
    reg_file_mp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(4), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .RA(ra), .RD(rd_a),
        .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
        .CLR_REQ(clr_req), .BUSY(busy_a), .CLR_DONE(done_a)
    );

    reg_file_mp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .RA(ra[2*AW-1:0]), .RD(rd_b),
        .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
        .CLR_REQ(clr_req), .BUSY(busy_b), .CLR_DONE(done_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input bit is_a, input logic [AW-1:0] a);
        if (!is_a) return mem_b[a];
        if (a == '0) return '0;
        if (clr_left == 0 && we1 && wa1 == a) return wd1;
        if (clr_left == 0 && we0 && wa0 == a) return wd0;
        return mem_a[a];
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            clr_left <= 0;
            done_m   <= 1'b0;
        end else if (clr_left > 0) begin
            mem_a[DEPTH-clr_left] <= '0;
            mem_b[DEPTH-clr_left] <= '0;
            clr_left <= clr_left - 1;
            done_m   <= (clr_left == 1);
        end else begin
            done_m <= 1'b0;
            if (we0) begin
                if (wa0 != '0) mem_a[wa0] <= wd0;
                mem_b[wa0] <= wd0;
            end
            if (we1) begin
                if (wa1 != '0) mem_a[wa1] <= wd1;
                mem_b[wa1] <= wd1;
            end
            if (clr_req) clr_left <= DEPTH;
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            for (int p = 0; p < 4; p++)
                check("rd_a", rd_a[p*DW +: DW], exp_rd(1'b1, ra[p*AW +: AW]));
            for (int p = 0; p < 2; p++)
                check("rd_b", rd_b[p*DW +: DW], exp_rd(1'b0, ra[p*AW +: AW]));
            check("busy_a", busy_a, clr_left > 0);
            check("busy_b", busy_b, clr_left > 0);
            check("done_a", done_a, done_m);
            check("done_b", done_b, done_m);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
        ra[0*AW +: AW] = AW'(a0);
        ra[1*AW +: AW] = AW'(a1);
        ra[2*AW +: AW] = AW'(a2);
        ra[3*AW +: AW] = AW'(a3);
    endtask

    initial begin
        int busy_cnt, done_cnt;
        RST_N = 1'b0;
        quiet();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
        @(posedge CLK); #3 RST_N = 1'b1;

        // Reset contents: every address reads zero on both configurations.
        for (int a = 0; a < DEPTH; a++) begin
            step(); set_ra(a, a, a, a);
            @(negedge CLK);
            check("reset_rd_a", rd_a[DW-1:0], 0);
            check("reset_rd_b", rd_b[2*DW-1:DW], 0);
        end
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);

        // Write with same-cycle read: forwarded on A, old value on B.
        step(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; set_ra(5, 5, 5, 5);
        @(negedge CLK);
        check("byp_a", rd_a[DW-1:0], 32'hDEADBEEF);
        check("nobyp_b", rd_b[DW-1:0], 0);
        step(); quiet();
        @(negedge CLK);
        check("stored_a", rd_a[DW-1:0], 32'hDEADBEEF);
        check("stored_b", rd_b[DW-1:0], 32'hDEADBEEF);

        // Collision: port 1 wins, both for storage and forwarding.
        step(); we0 = 1; wa0 = 7; wd0 = 32'h1111; we1 = 1; wa1 = 7; wd1 = 32'h2222;
        set_ra(7, 7, 7, 7);
        @(negedge CLK);
        check("coll_byp_a", rd_a[DW-1:0], 32'h2222);
        step(); quiet();
        @(negedge CLK);
        check("coll_a", rd_a[DW-1:0], 32'h2222);
        check("coll_b", rd_b[DW-1:0], 32'h2222);

        // Zero register on A; ordinary entry on B.
        step(); we0 = 1; wa0 = 0; wd0 = 32'hFFFF; set_ra(0, 0, 0, 0);
        @(negedge CLK);
        check("zero_byp_a", rd_a[DW-1:0], 0);
        step(); quiet();
        @(negedge CLK);
        check("zero_a", rd_a[DW-1:0], 0);
        check("zero_b", rd_b[DW-1:0], 32'hFFFF);

        // Four independent ports, one forwarded from WD1.
        step(); we0 = 1; wa0 = 10; wd0 = 32'hA0; we1 = 1; wa1 = 11; wd1 = 32'hB0;
        step(); we0 = 0; we1 = 1; wa1 = 12; wd1 = 32'hC5; set_ra(10, 11, 0, 12);
        @(negedge CLK);
        check("p0", rd_a[0*DW +: DW], 32'hA0);
        check("p1", rd_a[1*DW +: DW], 32'hB0);
        check("p2", rd_a[2*DW +: DW], 0);
        check("p3", rd_a[3*DW +: DW], 32'hC5);
        step(); quiet();

        // Bulk clear over a filled file, with a write attempted mid-clear.
        for (int a = 1; a < DEPTH; a++) begin
            we0 = 1; wa0 = AW'(a); wd0 = a;
            step();
        end
        quiet(); clr_req = 1;
        step(); clr_req = 0; set_ra(31, 1, 16, 30);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            if (i == 5) begin #2 we0 = 1; wa0 = 31; wd0 = 32'hABCD; end
            if (i == 6) begin #2 we0 = 0; end
        end
        check("clr_busy_cycles", busy_cnt, 32);
        check("clr_done_pulses", done_cnt, 1);
        for (int a = 0; a < DEPTH; a++) begin
            step(); set_ra(a, a, a, a);
            @(negedge CLK);
            check("cleared_a", rd_a[DW-1:0], 0);
            check("cleared_b", rd_b[DW-1:0], 0);
        end

        // Reset during a clear: entry 20 is not yet swept when reset hits.
        step(); we0 = 1; wa0 = 20; wd0 = 32'h77;
        step(); quiet(); clr_req = 1;
        step(); clr_req = 0; set_ra(20, 20, 20, 20);
        repeat (10) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_rd20_a", rd_a[DW-1:0], 0);
        check("rst_rd20_b", rd_b[DW-1:0], 0);
        @(posedge CLK); #3 RST_N = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done_a || busy_a) done_cnt++;
        end
        check("no_done_after_rst", done_cnt, 0);
        step(); we0 = 1; wa0 = 3; wd0 = 32'h55;
        step(); quiet(); set_ra(3, 3, 3, 3);
        @(negedge CLK);
        check("post_rst_a", rd_a[DW-1:0], 32'h55);
        check("post_rst_b", rd_b[DW-1:0], 32'h55);

        // Random traffic, clears included; per-cycle compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            step();
            we0 = ($urandom % 3) == 0;
            we1 = ($urandom % 3) == 0;
            wa0 = AW'($urandom);
            wa1 = ($urandom % 4 == 0) ? wa0 : AW'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            clr_req = ($urandom % 150) == 0;
            for (int p = 0; p < 4; p++) begin
                case ($urandom % 3)
                    0: ra[p*AW +: AW] = wa0;
                    1: ra[p*AW +: AW] = wa1;
                    default: ra[p*AW +: AW] = AW'($urandom);
                endcase
            end
        end
        step(); quiet();
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath. It generalises the single-write, two-read file to NUM_RD read ports, two write ports, optional write-to-read bypass and an optional hardwired zero register.
- Adds asynchronous reset of all entries and a sequential bulk-clear engine, used for context flush and for self-test.

Parameters:
- DATA_WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; power of two, at least 2.
- NUM_RD, 2, number of read ports; 1 to 4.
- BYPASS, 1, 1 means a same-cycle write is forwarded to the read outputs; 0 means reads return stored contents only.
- ZERO_REG, 1, 1 means entry 0 always reads 0 and writes to it are dropped.
- Derived localparam AW = clog2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RA  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW].
- RD  out  NUM_RD*DATA_WIDTH  read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]; combinational.
- WE0  in  1  write enable, port 0.
- WA0  in  AW  write address, port 0.
- WD0  in  DATA_WIDTH  write data, port 0.
- WE1  in  1  write enable, port 1.
- WA1  in  AW  write address, port 1.
- WD1  in  DATA_WIDTH  write data, port 1.
- CLR_REQ  in  1  request a bulk clear; level-sampled while IDLE.
- BUSY  out  1  high while clear in progress.
- CLR_DONE  out  1  one-cycle pulse after the last entry is cleared.

Behaviour:
- Interface: one clock (CLK). Reset RST_N is asynchronous and active-low.
- Reset (RST_N=0, asynchronous): all entries set to 0; FSM forced to IDLE; clear index set to 0; BUSY=0; CLR_DONE=0. RD therefore reads 0 during and after reset.
- Writes (IDLE only):
  - On posedge, if WEk is set, entry[WAk] takes WDk.
  - If WE0 and WE1 are both set with WA0==WA1, port 1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads:
  - Combinational, so zero latency.
  - With ZERO_REG=1, RA port = 0 returns 0 regardless of bypass.
  - With BYPASS=1 in IDLE, a read address matching an active write address returns that write's data. Port 1 has priority on a double match, mirroring write priority.
  - With BYPASS=0, reads return stored contents; new data is visible the cycle after the write.
- FSM states: IDLE and CLEARING.
  - IDLE to CLEARING: on posedge with CLR_REQ=1. The clear index loads 0 and BUSY rises next cycle.
  - CLEARING: each cycle entry[idx] is set to 0 and idx increments.
    - WE0 and WE1 are ignored: writes are dropped, not queued.
    - Bypass is disabled.
    - Reads return current stored contents, so the file may be partially cleared.
    - CLR_REQ is ignored.
  - CLEARING to IDLE: in the cycle idx==DEPTH-1 is written. In the following cycle BUSY=0 and CLR_DONE=1 for exactly one cycle. idx wraps to 0.
  - Clear duration: exactly DEPTH cycles of BUSY=1.
  - CLR_REQ held high continuously: a new clear starts on the cycle CLR_DONE is high, because the FSM is in IDLE then. This back-to-back operation is legal.
- Reset mid-clear: the asynchronous reset wins immediately. All entries become 0, the FSM returns to IDLE, and there is no CLR_DONE pulse.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.
- No X on RD after reset for any address.

Decomposition:
- Shared package mips_pkg holds:
  - clog2 function;
  - FSM state encoding: IDLE=1'b0, CLEARING=1'b1;
  - default DATA_WIDTH and DEPTH constants.
- One sub-module, rf_read_port, is natural: address to data mux plus bypass and zero-register logic, instantiated NUM_RD times via generate.
- Storage, write arbitration and clear FSM stay in the top module.

Test Plan:
- Reset then read: assert RST_N=0 mid-cycle, release, read all 32 addresses on both ports -> every RD = 0, BUSY=0, CLR_DONE=0.
- Write, read and bypass (BYPASS=1): WE0 with WA0=5, WD0=32'hDEADBEEF and RA0=5 in the same cycle -> RD0=32'hDEADBEEF that cycle. Next cycle with WE0=0 -> still 32'hDEADBEEF. Same test with BYPASS=0 -> old value 0, then 32'hDEADBEEF.
- Dual-write collision: WE0 with WA0=7, WD0=32'h1111 and WE1 with WA1=7, WD1=32'h2222 -> entry 7 = 32'h2222 and bypassed RD = 32'h2222. Write to address 0 with 32'hFFFF -> RD for address 0 = 0.
- Bulk clear: fill entries 1-31 with their own index, pulse CLR_REQ -> BUSY high for 32 cycles, then CLR_DONE for 1 cycle. A WE0 issued mid-clear to address 31 with 32'hABCD is dropped. All entries read 0 afterwards.
- Reset mid-clear: assert RST_N=0 at clear cycle 10 -> BUSY falls asynchronously, no CLR_DONE, all entries 0. A subsequent write to address 3 with 32'h55 reads back 32'h55.
- NUM_RD=4 configuration: four different read addresses in one cycle, one of them matching WE1 -> each RD port returns the correct independent value, with the bypassed port returning WD1.
